cmp_rr_scheduler: RTL and testbench

// - Round-robin scheduler sharing one 2-bit comparator / RGB-LED datapath (a0,a1,b0,b1 -> r,g,b)

---
 rtl/cmp_sched_pkg.sv | 19 +
 rtl/rr_arbiter.sv | 32 +++
 rtl/cmp_rr_scheduler.sv | 144 ++++++++++++++
 tb/tb_cmp_rr_scheduler.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/cmp_sched_pkg.sv
// Shared types for the round-robin comparator scheduler.
package cmp_sched_pkg;

  // Width of each operand handed to the comparator.
  localparam int OPW = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    HOLD   = 2'd2
  } state_t;

  typedef struct packed {
    logic r;
    logic g;
    logic b;
  } rgb_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotating-priority arbiter: the first set request at or
// after ptr (wrapping N-1 -> 0) wins. The pointer itself is held by the caller.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  input  logic          en,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] winner
);

  // Scan offsets from farthest to nearest so the nearest request overrides.
  always_comb begin
    int idx;
    gnt    = '0;
    winner = '0;
    idx    = 0;
    if (en) begin
      for (int i = N - 1; i >= 0; i--) begin
        idx = (int'(ptr) + i) % N;
        if (req[idx]) begin
          gnt      = '0;
          gnt[idx] = 1'b1;
          winner   = PW'(idx);
        end
      end
    end
  end

endmodule

// File: rtl/cmp_rr_scheduler.sv
// Round-robin scheduler that shares one external 2-bit comparator / RGB LED
// datapath among NREQ requesters: grant, drive operands, capture, hold.
module cmp_rr_scheduler
  import cmp_sched_pkg::*;
#(
  parameter int NREQ        = 4,
  parameter int HOLD_CYCLES = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NREQ-1:0]     req,
  input  logic [2*NREQ-1:0]   op_a,
  input  logic [2*NREQ-1:0]   op_b,
  output logic [NREQ-1:0]     gnt,
  output logic                done,
  output logic [2:0]          res_rgb,
  output logic                busy,
  output logic                cmp_a0,
  output logic                cmp_a1,
  output logic                cmp_b0,
  output logic                cmp_b1,
  input  logic                cmp_r,
  input  logic                cmp_g,
  input  logic                cmp_b,
  output logic                led_r,
  output logic                led_g,
  output logic                led_b
);

  localparam int PW = $clog2(NREQ);
  localparam int CW = $clog2(HOLD_CYCLES + 1);

  state_t            state_q, state_d;
  logic [PW-1:0]     ptr_q, ptr_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic              done_q, done_d;
  rgb_t              res_q, res_d;
  rgb_t              led_q, led_d;
  logic [OPW-1:0]    opa_q, opa_d;
  logic [OPW-1:0]    opb_q, opb_d;

  logic [NREQ-1:0]   arb_gnt;
  logic [PW-1:0]     arb_win;
  logic              arb_en;
  rgb_t              cmp_rgb;

  assign arb_en  = (state_q == IDLE);
  assign cmp_rgb = {cmp_r, cmp_g, cmp_b};

  rr_arbiter #(.N(NREQ), .PW(PW)) u_arb (
    .req    (req),
    .ptr    (ptr_q),
    .en     (arb_en),
    .gnt    (arb_gnt),
    .winner (arb_win)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state: one settle cycle, then HOLD_CYCLES of dwell.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (|req) state_d = SETTLE;
      SETTLE:  state_d = HOLD;
      HOLD:    if (cnt_q == '0) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath next values: latch operands at grant, capture result after settle.
  always_comb begin
    ptr_d  = ptr_q;
    cnt_d  = cnt_q;
    gnt_d  = gnt_q;
    done_d = 1'b0;
    res_d  = res_q;
    led_d  = led_q;
    opa_d  = opa_q;
    opb_d  = opb_q;
    case (state_q)
      IDLE: begin
        if (|req) begin
          gnt_d = arb_gnt;
          opa_d = op_a[arb_win*OPW +: OPW];
          opb_d = op_b[arb_win*OPW +: OPW];
          ptr_d = (arb_win == PW'(NREQ - 1)) ? '0 : arb_win + PW'(1);
        end
      end
      SETTLE: begin
        res_d  = cmp_rgb;
        led_d  = cmp_rgb;
        done_d = 1'b1;
        cnt_d  = CW'(HOLD_CYCLES - 1);
      end
      HOLD: begin
        if (cnt_q == '0) gnt_d = '0;
        else             cnt_d = cnt_q - CW'(1);
      end
      default: ;
    endcase
  end

  // Datapath registers; reset also aborts any transaction in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q  <= '0;
      cnt_q  <= '0;
      gnt_q  <= '0;
      done_q <= 1'b0;
      res_q  <= '0;
      led_q  <= '0;
      opa_q  <= '0;
      opb_q  <= '0;
    end else begin
      ptr_q  <= ptr_d;
      cnt_q  <= cnt_d;
      gnt_q  <= gnt_d;
      done_q <= done_d;
      res_q  <= res_d;
      led_q  <= led_d;
      opa_q  <= opa_d;
      opb_q  <= opb_d;
    end
  end

  assign gnt     = gnt_q;
  assign done    = done_q;
  assign res_rgb = res_q;
  assign busy    = (state_q != IDLE);
  assign cmp_a0  = opa_q[0];
  assign cmp_a1  = opa_q[1];
  assign cmp_b0  = opb_q[0];
  assign cmp_b1  = opb_q[1];
  assign led_r   = led_q.r;
  assign led_g   = led_q.g;
  assign led_b   = led_q.b;

endmodule

// File: tb/tb_cmp_rr_scheduler.sv
// Randomized and directed bench for cmp_rr_scheduler with a transaction-level
// reference model (cycles elapsed since grant) and a behavioural comparator.
module tb_cmp_rr_scheduler;

  localparam int NREQ = 4;
  localparam int HOLD = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic [NREQ-1:0] req;
  logic [2*NREQ-1:0] op_a, op_b;
  logic [NREQ-1:0] gnt;
  logic            done, busy;
  logic [2:0]      res_rgb;
  logic            cmp_a0, cmp_a1, cmp_b0, cmp_b1;
  logic            cmp_r, cmp_g, cmp_b;
  logic            led_r, led_g, led_b;

  int n_checks = 0;
  int n_errors = 0;
  int cycle    = 0;

  // Reference model state
  int         m_since = -1;   // cycles since grant edge, -1 when idle
  int         m_ptr   = 0;
  int         m_win   = 0;
  logic [1:0] m_ca = '0, m_cb = '0;
  logic [2:0] m_res = '0, m_led = '0;

  always #5 clk = ~clk;

  // System-level comparator.
  assign cmp_r = ({cmp_a1, cmp_a0} >  {cmp_b1, cmp_b0});
  assign cmp_g = ({cmp_a1, cmp_a0} == {cmp_b1, cmp_b0});
  assign cmp_b = ({cmp_a1, cmp_a0} <  {cmp_b1, cmp_b0});

  cmp_rr_scheduler #(.NREQ(NREQ), .HOLD_CYCLES(HOLD)) dut (
    .clk(clk), .rst(rst), .req(req), .op_a(op_a), .op_b(op_b),
    .gnt(gnt), .done(done), .res_rgb(res_rgb), .busy(busy),
    .cmp_a0(cmp_a0), .cmp_a1(cmp_a1), .cmp_b0(cmp_b0), .cmp_b1(cmp_b1),
    .cmp_r(cmp_r), .cmp_g(cmp_g), .cmp_b(cmp_b),
    .led_r(led_r), .led_g(led_g), .led_b(led_b)
  );

  function automatic logic [2:0] cmp_model(input logic [1:0] a, input logic [1:0] b);
    int ia, ib;
    ia = int'(a);
    ib = int'(b);
    return {ia > ib, ia == ib, ia < ib};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s @cycle %0d: got 0x%0h expected 0x%0h", tag, cycle, got, exp);
    end
  endtask

  // Advance one clock, update the model from the inputs seen at the edge, compare.
  task automatic step();
    logic [NREQ-1:0] e_gnt;
    @(posedge clk);
    if (rst) begin
      m_since = -1; m_ptr = 0; m_ca = '0; m_cb = '0; m_res = '0; m_led = '0;
    end else if (m_since < 0) begin
      if (req != '0) begin
        for (int k = 0; k < NREQ; k++) begin
          int idx;
          idx = (m_ptr + k) % NREQ;
          if (req[idx]) begin
            m_win = idx;
            break;
          end
        end
        m_ca    = op_a[2*m_win +: 2];
        m_cb    = op_b[2*m_win +: 2];
        m_ptr   = (m_win + 1) % NREQ;
        m_since = 0;
      end
    end else begin
      m_since++;
      if (m_since == 1) begin
        m_res = cmp_model(m_ca, m_cb);
        m_led = m_res;
      end
      if (m_since == HOLD + 1) m_since = -1;
    end
    #1;
    cycle++;
    e_gnt = (m_since >= 0) ? NREQ'(1 << m_win) : '0;
    check("gnt",  32'(gnt),  32'(e_gnt));
    check("done", 32'(done), 32'(m_since == 1));
    check("busy", 32'(busy), 32'(m_since >= 0));
    check("res",  32'(res_rgb), 32'(m_res));
    check("led",  32'({led_r, led_g, led_b}), 32'(m_led));
    check("cmp_a", 32'({cmp_a1, cmp_a0}), 32'(m_ca));
    check("cmp_b", 32'({cmp_b1, cmp_b0}), 32'(m_cb));
  endtask

  task automatic run_until_done(input int max);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < max && !seen; i++) begin
      step();
      if (done) seen = 1'b1;
    end
    if (!seen) check("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_idle(input int max);
    int i;
    i = 0;
    while (busy && i < max) begin
      step();
      i++;
    end
    if (busy) check("idle_timeout", 32'd1, 32'd0);
  endtask

  initial begin
    logic [NREQ-1:0] seq_gnt[$];
    int              seq_cyc[$];
    logic [NREQ-1:0] prev_gnt;
    logic [NREQ-1:0] exp_order [5];
    bit              saw_done;

    rst = 1'b1; req = '0; op_a = '0; op_b = '0;
    step(); step();
    check("rst_gnt",  32'(gnt), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_led",  32'({led_r, led_g, led_b}), 32'd0);
    rst = 1'b0;

    // Idle: no requests for 50 cycles.
    for (int i = 0; i < 50; i++) step();

    // Single request from requester 0.
    req = 4'b0001; op_a[1:0] = 2'b10; op_b[1:0] = 2'b01;
    step();
    check("s1_gnt", 32'(gnt), 32'b0001);
    run_until_done(5);
    check("s1_res", 32'(res_rgb), 32'b100);
    req = '0;
    wait_idle(20);
    for (int i = 0; i < 3; i++) step();
    check("s1_led_hold", 32'({led_r, led_g, led_b}), 32'b100);

    // All four requesting permanently; fresh pointer after reset.
    rst = 1'b1; step(); rst = 1'b0;
    req = 4'b1111; op_a = 8'hFF; op_b = 8'hFF;
    prev_gnt = '0;
    for (int i = 0; i < 45; i++) begin
      step();
      if (prev_gnt == '0 && gnt != '0) begin
        seq_gnt.push_back(gnt);
        seq_cyc.push_back(cycle);
      end
      prev_gnt = gnt;
    end
    exp_order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    check("s2_ngrants", 32'(seq_gnt.size()), 32'd5);
    for (int i = 0; i < 5 && i < seq_gnt.size(); i++) begin
      check("s2_order", 32'(seq_gnt[i]), 32'(exp_order[i]));
      if (i > 0) check("s2_spacing", 32'(seq_cyc[i] - seq_cyc[i-1]), 32'(2 + HOLD));
    end
    check("s2_res", 32'(res_rgb), 32'b010);
    req = '0;
    wait_idle(20);

    // Operand change during SETTLE must be ignored.
    req = 4'b0100; op_a = '0; op_b = '0; op_b[5:4] = 2'b11;
    step();
    check("s3_gnt", 32'(gnt), 32'b0100);
    op_a[5:4] = 2'b11;
    run_until_done(5);
    check("s3_res", 32'(res_rgb), 32'b001);
    req = '0;
    wait_idle(20);

    // Reset during HOLD cycle 3.
    req = 4'b0010; op_a = 8'h0C; op_b = 8'h00;
    for (int i = 0; i < 20 && m_since != 3; i++) step();
    check("s4_reached_hold3", 32'(m_since), 32'd3);
    req = '0;
    rst = 1'b1;
    step();
    check("s4_gnt",  32'(gnt), 32'd0);
    check("s4_busy", 32'(busy), 32'd0);
    check("s4_led",  32'({led_r, led_g, led_b}), 32'd0);
    rst = 1'b0;
    saw_done = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (done) saw_done = 1'b1;
    end
    check("s4_no_done", 32'(saw_done), 32'd0);
    req = 4'b1000;
    step();
    check("s4_gnt3", 32'(gnt), 32'b1000);
    run_until_done(5);
    req = '0;
    wait_idle(20);

    // Exhaustive operand sweep through requester 1.
    for (int a = 0; a < 4; a++) begin
      for (int b = 0; b < 4; b++) begin
        req = 4'b0010;
        op_a = 8'($urandom); op_b = 8'($urandom);
        op_a[3:2] = 2'(a); op_b[3:2] = 2'(b);
        run_until_done(5);
        check("s5_res", 32'(res_rgb), 32'(cmp_model(2'(a), 2'(b))));
        req = '0;
        wait_idle(20);
        step();
      end
    end

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      req  = NREQ'($urandom);
      op_a = 8'($urandom);
      op_b = 8'($urandom);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
